// File: rtl/mult_pkg.sv
// Shared types and width constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_N   = 4;
  localparam int MULT_P_W = 2 * MULT_N;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mult_adder_n.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: combinational, zero cycles.
// Backpressure: none, pure combinational datapath element.
module mult_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic half;
    assign half       = a[i] ^ b[i];
    assign sum[i]     = half ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & half);
  end

  assign cout = carry[N];

endmodule

// File: rtl/mult_seq_shift_add.sv
// Sequential unsigned shift-and-add multiplier, P = A*B, one add/shift per clock; MULT_OVF_EN adds OVF.
// Latency: start accepted at edge k, done strobes in the cycle after edge k+N; fixed, no early exit.
// Backpressure: start is ignored while busy; operands are captured on acceptance and may then change.
module mult_seq_shift_add
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
`ifdef MULT_OVF_EN
  ,
  output logic           OVF
`endif
);

  localparam int CNT_W = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [N:0]       acc_q;
  logic [N-1:0]     mplr_q;
  logic [N-1:0]     mcand_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0]     add_sum;
  logic             add_co;
  logic [N:0]       acc_add;
  logic [N:0]       acc_sh;
  logic [N-1:0]     mplr_sh;
  logic             last;
  logic             load;

  mult_adder_n #(.N(N)) u_adder (
    .a    (acc_q[N-1:0]),
    .b    (mcand_q),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Carry lands in acc[N], then the whole {acc, mplr} pair shifts right once.
  assign acc_add = mplr_q[0] ? {add_co, add_sum} : acc_q;
  assign acc_sh  = {1'b0, acc_add[N:1]};
  assign mplr_sh = {acc_add[0], mplr_q[N-1:1]};
  assign last    = (cnt_q == CNT_W'(N - 1));
  assign load    = start && ((state_q == IDLE) || (state_q == DONE));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      P       <= '0;
`ifdef MULT_OVF_EN
      OVF     <= 1'b0;
`endif
    end else if (load) begin
      mcand_q <= A;
      mplr_q  <= B;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q  <= acc_sh;
      mplr_q <= mplr_sh;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) begin
        // Product is taken from the post-shift value; acc_sh[N] is always zero here.
        P <= {acc_sh[N-1:0], mplr_sh};
`ifdef MULT_OVF_EN
        OVF <= |acc_sh[N-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Directed self-checking bench for mult_seq_shift_add with N=4.
module tb_mult_seq_shift_add;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;
`ifdef MULT_OVF_EN
  logic           OVF;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_shift_add #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
`ifdef MULT_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (RUN cycle 1).
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = 4'($urandom);
    B     = 4'($urandom);
  endtask

  // Walks negedges until done or the budget runs out; cyc counts cycles since the start edge.
  task automatic wait_done(input int cyc0, output int cyc, output int busy_n);
    cyc    = cyc0;
    busy_n = 0;
    while (!done && cyc <= 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic mult_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp);
    int cyc;
    int bn;
    start_op(a, b);
    wait_done(1, cyc, bn);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(bn), 32'd4);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_p"}, 32'(P), 32'(exp));
`ifdef MULT_OVF_EN
    chk({tag, "_ovf"}, 32'(OVF), 32'(exp > 8'd15));
`endif
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bn;
    int extra;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_p", 32'(P), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef MULT_OVF_EN
    chk("rst_ovf", 32'(OVF), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    mult_op("max", 4'd15, 4'd15, 8'hE1);
    mult_op("zero_a", 4'd0, 4'd9, 8'h00);
    mult_op("zero_b", 4'd9, 4'd0, 8'h00);

    // Second start during RUN must be ignored.
    start_op(4'd3, 4'd6);
    @(negedge clk);
    start = 1'b1;
    A     = 4'd1;
    B     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc, bn);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_lat", 32'(cyc), 32'd5);
    chk("ign_p", 32'(P), 32'h12);
`ifdef MULT_OVF_EN
    chk("ign_ovf", 32'(OVF), 32'd1);
`endif
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("ign_no_second_op", 32'(extra), 32'd0);

    // Back-to-back: start held during the DONE cycle.
    start_op(4'd5, 4'd5);
    wait_done(1, cyc, bn);
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_p", 32'(P), 32'h19);
    start_op(4'd2, 4'd7);
    chk("b2b_busy_next", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(1, cyc, bn);
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_second_lat", 32'(cyc), 32'd5);
    chk("b2b_second_p", 32'(P), 32'h0E);
`ifdef MULT_OVF_EN
    chk("b2b_second_ovf", 32'(OVF), 32'd0);
`endif
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done.
    start_op(4'd7, 4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_p", 32'(P), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    chk("abort_p_held", 32'(P), 32'd0);
    mult_op("after_abort", 4'd7, 4'd7, 8'h31);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mult_op("sweep", 4'(a), 4'(b), 8'(a * b));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_shift_add.md
Name: mult_seq_shift_add

Overview:
Sequential unsigned shift-and-add multiplier; the inverse operation of the team's combinational restoring divider. It computes P = A × B over N iterations, one add/shift per clock. It sits in the calculator datapath beside the divider. Operands are captured on a start pulse, and a registered product is returned with a done strobe.

Parameters:
N, 4, operand width in bits; product width is 2N.
CNT_W, $clog2(N+1), width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
A  input  N  multiplicand, captured when start is accepted.
B  input  N  multiplier, captured when start is accepted.
P  output  2N  product, registered; holds the last result.
busy  output  1  high while in RUN.
done  output  1  one-cycle strobe when P becomes valid.
OVF  output  1  present only with MULT_OVF_EN; see Optional Feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n, clk).
  - Values while rst_n=0: state=IDLE, P=0, busy=0, done=0, OVF=0, internal acc/mplr/mcand/cnt=0.
- States:
  - IDLE: start=1 -> load mcand=A, mplr=B, acc=0 (N+1 bits incl. carry), cnt=0; go to RUN.
  - RUN: each cycle:
    - if mplr[0] then acc = acc[N-1:0] + mcand (N+1-bit sum, carry kept in acc[N]);
    - then shift {acc, mplr} right by 1, with acc[N] shifted into acc[N-1];
    - cnt++.
    - When cnt reaches N-1 on this update, go to DONE and register P = {acc, mplr} after the final shift.
  - DONE: done=1 for exactly this cycle. start=1 here -> behaves as in IDLE (back-to-back, go to RUN); otherwise go to IDLE.
- Latency: start sampled at edge k -> RUN during edges k+1..k+N -> done=1 in the cycle after edge k+N.
  - Latency is fixed at N cycles regardless of operand values; no early termination.
- busy=1 exactly in RUN. done and busy are never high together.
- start while in RUN is ignored; no queuing. A and B may change freely after acceptance.
- P changes only on the DONE-entry edge and holds until the next completion. P is not cleared by a new start.
- Arithmetic is unsigned only. Max product (2^N-1)^2 fits in 2N bits, so no truncation occurs internally.
- Reset mid-RUN aborts immediately: outputs return to reset values and no done is produced.

Optional Feature:
MULT_OVF_EN
- Defined: adds output OVF, registered together with P. OVF=1 iff product > 2^N-1, i.e. P[2N-1:N] != 0.
  - This mirrors the divider's ERR flag for the calculator's N-bit display.
  - OVF holds with P and resets to 0.
- Undefined: the OVF port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, RUN, DONE} (2 bits);
  - default width constant MULT_N=4;
  - localparam for product width.
- One sub-module, mult_adder_n: an N-bit ripple adder with carry-out, built from the team's full-adder cells.
  - It is instantiated once in the RUN datapath.

Test Plan:
- Reset then start with A=15, B=15 -> busy=1 for 4 cycles; done pulses in the 5th cycle after the start edge; P=8'hE1 (225); OVF=1 if enabled.
- A=0, B=9 and A=9, B=0 -> P=8'h00 after exactly 4 RUN cycles; OVF=0.
- Start with A=3, B=6; pulse start again at RUN cycle 2 with A=1, B=1 -> second start ignored; P=8'h12 (18); OVF=1.
- Back-to-back: start held during DONE of 5×5 with A=2, B=7 -> first done gives P=8'h19; busy rises the next cycle; second done gives P=8'h0E.
- Drop rst_n during RUN cycle 2 of 7×7 -> P, busy, done go to 0 immediately; no done afterwards; a fresh start of 7×7 gives P=8'h31.
- Exhaustive sweep, all 256 A,B pairs -> P == A*B; OVF == (A*B > 15); done exactly once per accepted start.
